// File: rtl/debounce.sv
// Single-bit debouncer: a synchronizer chain followed by a stability counter.
// out follows the synchronized input only after it has held a new level for STABLE_CYCLES edges.
module debounce #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 3,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {SYNC_STAGES{INIT_LEVEL}};
    else     sync <= {sync[SYNC_STAGES-2:0], in};
  end

  // Any sample matching out restarts qualification, so a bounce back cancels a pending change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= INIT_LEVEL;
      cnt <= '0;
    end else if (s == out) begin
      cnt <= '0;
    end else if (cnt >= LAST) begin
      out <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: three parameterizations share one input; a history-based model
// feeds an expected-value queue that a negedge monitor drains, plus directed latency/glitch checks.
module tb_debounce;
  localparam int SY [3] = '{2, 3, 3};
  localparam int ST [3] = '{3, 1, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in  = 1'b0;
  logic [2:0] outs;

  int ntests = 0;
  int nfail  = 0;

  debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(3), .INIT_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in(in), .out(outs[0]));
  debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .INIT_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in(in), .out(outs[1]));
  debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(8), .INIT_LEVEL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in(in), .out(outs[2]));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    ntests++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // Reference model: keeps every input sample since reset. The level seen by the filter at
  // edge n is the input sampled SY edges earlier; out flips when the last ST such levels all
  // differ from out and all of them came after the previous flip.
  logic       hist [$];
  int         nedge = 0;
  logic       mout [3] = '{1'b0, 1'b0, 1'b0};
  int         last_t [3] = '{0, 0, 0};
  logic [2:0] exp_q [$];

  function automatic logic s_at(input int n, input int c);
    if (n - SY[c] >= 1) return hist[n - SY[c] - 1];
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    nedge = 0;
    for (int c = 0; c < 3; c++) begin
      mout[c]   = 1'b0;
      last_t[c] = 0;
    end
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      hist.push_back(in);
      nedge++;
      for (int c = 0; c < 3; c++) begin
        if (nedge - last_t[c] >= ST[c]) begin
          logic ok;
          ok = 1'b1;
          for (int j = 0; j < ST[c]; j++)
            if (s_at(nedge - j, c) == mout[c]) ok = 1'b0;
          if (ok) begin
            mout[c]   = ~mout[c];
            last_t[c] = nedge;
          end
        end
      end
    end
    exp_q.push_back({mout[2], mout[1], mout[0]});
  end

  // Monitor: every output sample is compared with the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      for (int c = 0; c < 3; c++)
        check($sformatf("sb_dut%0d", c), int'(outs[c]), int'(e[c]));
    end
  end

  // Output transition counters for the no-change checks.
  int         nchg [3] = '{0, 0, 0};
  logic [2:0] prev = 3'b000;
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++)
      if (outs[c] !== prev[c]) nchg[c]++;
    prev <= outs;
  end

  // Drive v so that exactly n rising edges sample it.
  task automatic hold(input logic v, input int n);
    @(negedge clk);
    in = v;
    repeat (n) @(posedge clk);
  endtask

  // Apply v before the next edge (E0 = edge 1) and record the edge on which each out reaches v.
  int lat [3];
  task automatic measure(input logic v);
    for (int c = 0; c < 3; c++) lat[c] = 0;
    in = v;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++)
        if (lat[c] == 0 && outs[c] == v) lat[c] = n;
    end
  endtask

  task automatic check_lat(input string name);
    for (int c = 0; c < 3; c++)
      check($sformatf("%s_dut%0d", name, c), lat[c], SY[c] + ST[c]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c2, r, f;
    logic cur;

    // Bounce pattern on absolute times.
    rst = 1'b1;
    #2  rst = 1'b0;
    #6  in = 1'b1;   // 8
    #3  in = 1'b0;   // 11
    #3  in = 1'b1;   // 14
    #3  in = 1'b0;   // 17
    #4  in = 1'b1;   // 21
    #3  in = 1'b0;   // 24
    #3  in = 1'b1;   // 27
    #43 check("bounce_70", int'(outs[0]), 0);
    #3  in = 1'b0;   // 73
    #3  in = 1'b1;   // 76
    #3  in = 1'b0;   // 79
    #1  check("bounce_80", int'(outs[0]), 1);
    #3  in = 1'b1;   // 83
    #3  in = 1'b0;   // 86
    #2  in = 1'b1;   // 88
    #3  in = 1'b0;   // 91
    #39 check("bounce_130", int'(outs[0]), 1);
    #10 check("bounce_140", int'(outs[0]), 0);

    // Reset held with in=1 while clocking, then the full latency after release.
    #1 rst = 1'b1; in = 1'b1;
    #1 check("rst_async", int'(outs), 0);
    repeat (4) begin
      @(negedge clk);
      check("rst_hold", int'(outs), 0);
    end
    #1 rst = 1'b0;
    measure(1'b1);
    check_lat("lat_rise");
    @(negedge clk);
    measure(1'b0);
    check_lat("lat_fall");

    // Reset mid-qualification discards the partial count.
    @(negedge clk);
    in = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_midcount", int'(outs), 0);
    #1 rst = 1'b0;
    measure(1'b1);
    check_lat("lat_after_rst");
    @(negedge clk);
    measure(1'b0);

    // Single-edge glitches in both directions.
    hold(1'b0, 15);
    c0 = nchg[0]; c2 = nchg[2];
    hold(1'b1, 1);
    hold(1'b0, 12);
    check("glitch_hi_dut0", nchg[0] - c0, 0);
    check("glitch_hi_dut2", nchg[2] - c2, 0);
    hold(1'b1, 15);
    c0 = nchg[0]; c2 = nchg[2];
    hold(1'b0, 1);
    hold(1'b1, 12);
    check("glitch_lo_dut0", nchg[0] - c0, 0);
    check("glitch_lo_dut2", nchg[2] - c2, 0);
    check("glitch_lo_level", int'(outs[0]), 1);

    // Pulse sampled on exactly three edges.
    hold(1'b0, 15);
    @(negedge clk);
    in = 1'b1;
    r = 0; f = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) in = 1'b0;
      if (r == 0 && outs[0] == 1'b1) r = n;
      if (r != 0 && f == 0 && outs[0] == 1'b0) f = n;
    end
    check("pulse_rise_edge", r, 5);
    check("pulse_fall_edge", f, 8);

    // Repeatedly interrupted change never qualifies.
    hold(1'b0, 15);
    c0 = nchg[0];
    repeat (12) begin
      hold(1'b1, 2);
      hold(1'b0, 1);
    end
    hold(1'b0, 12);
    check("interrupted_dut0", nchg[0] - c0, 0);
    check("interrupted_level", int'(outs[0]), 0);

    // Random runs with intra-cycle glitches and occasional async resets.
    cur = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 check("rand_rst", int'(outs), 0);
        #1 rst = 1'b0;
      end else begin
        if ($urandom_range(0, 5) == 0) cur = ~cur;
        #1;
        if ($urandom_range(0, 3) == 0) begin
          in = ~cur;
          #1;
        end
        in = cur;
      end
    end
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/debounce.md
Name: debounce

Overview:
- Single-bit debouncer/glitch filter for a raw asynchronous input such as a push-button or switch.
- The input passes through a synchronizer chain, then a stability counter.
- The output changes only after the synchronized input has held a new level for STABLE_CYCLES consecutive clock edges.
- Sits between a board-level input pin and synchronous control logic. Filtering is symmetric: it applies to both rising and falling transitions.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer chain; legal values are 2 or more.
- STABLE_CYCLES, 3, number of consecutive differing synchronized samples required before out toggles; legal values are 1 or more.
- INIT_LEVEL, 1'b0, value loaded into out and every synchronizer flop on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in   input  1  raw, possibly bouncing, asynchronous input.
- out  output 1  debounced level, registered.

Behaviour:
- Reset:
  - While rst=1, all of the following hold immediately, independent of clk: out=INIT_LEVEL, every sync flop=INIT_LEVEL, cnt=0.
  - Reset asserted mid-count discards the partial count.
  - The first rising edge after deassertion runs normal operation.
- Synchronizer:
  - sync[0] <= in; sync[i] <= sync[i-1].
  - The sampled level s = sync[SYNC_STAGES-1].
  - Pulses or glitches on in that do not span a rising edge are never seen.
- Stability counter cnt:
  - Width is clog2(STABLE_CYCLES)+1 bits, with no wrap.
  - At each rising edge, using pre-edge values:
    - s == out: cnt <= 0.
    - s != out and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
    - s != out and cnt == STABLE_CYCLES-1: out <= s and cnt <= 0.
- Any single edge with s == out restarts qualification from zero. A bounce back to the current level therefore cancels a pending change.
- Latency:
  - A clean level change on in, setting up before edge E0, appears on out at edge E0 + SYNC_STAGES + STABLE_CYCLES - 1.
  - With defaults, that is the 5th rising edge counting E0.
- Minimum accepted pulse: SYNC_STAGES + STABLE_CYCLES - 1 is the latency only. A pulse is accepted only if it is sampled at STABLE_CYCLES consecutive edges; shorter pulses are fully rejected.
- STABLE_CYCLES=1 degenerates to a pure synchronizer: out follows s one edge later.
- out is driven only from the flop; there is no combinational path from in to out.
- No other outputs and no handshake.

Test Plan:
1. Reset behaviour: drive rst=1 with in=1, toggling clk -> out=0 and remains 0. Assert rst mid-qualification, i.e. after 2 differing edges -> out=0, cnt=0; after release the full 5-edge latency applies again.
2. Bounce pattern, period 10 ns, rising edges at 5, 15, 25 ns and so on; rst high 0–2 ns.
   - Stimulus on in:
     - in=1 at 8 ns
     - in=0 at 11 ns
     - in=1 at 14 ns
     - in=0 at 17 ns
     - in=1 at 21 ns
     - in=0 at 24 ns
     - in=1 at 27 ns
     - in=0 at 73 ns
     - in=1 at 76 ns
     - in=0 at 79 ns
     - in=1 at 83 ns
     - in=0 at 86 ns
     - in=1 at 88 ns
     - in=0 at 91 ns
   - Required response: out stays 0 until the 75 ns edge, is 1 from 75 ns to 135 ns, and returns to 0 at the 135 ns edge, with no other transitions.
3. Single-cycle glitch: in held 0, one pulse of 1 covering exactly one rising edge -> out never leaves 0. Same test with in held 1 and a 0 glitch -> out stays 1.
4. Pulse that is exactly long enough: in=1 sampled at 3 consecutive edges then 0 -> out goes 1 on the 5th edge after first sampling. It returns to 0 five edges after the first 0 sample.
5. Parameter sweep: STABLE_CYCLES=1 and STABLE_CYCLES=8, SYNC_STAGES=3, with a clean step on in -> out latency equals SYNC_STAGES + STABLE_CYCLES - 1 edges after the capturing edge in every case.
6. Repeated interrupted change: in 1 for 2 sampled edges, 0 for 1, 1 for 2, and so on indefinitely -> out remains 0. cnt never reaches STABLE_CYCLES-1 with a differing sample.
